// File: rtl/cache_pkg.sv
// Cache-side state enums, including the RAM port arbiter FSM.
package cache_pkg;
  localparam int unsigned BLOCK_WORDS = 2;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_FETCH
  } icache_state_t;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_WB0,
    DC_WB1,
    DC_LD0,
    DC_LD1
  } dcache_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IGRANT,
    ARB_DGRANT
  } arb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: RAM handshake state and the machine word.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;
endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of data-cache completions, cleared when the icache
// gets its turn. hit_o flags the completion that reaches the limit.
module arb_fair_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o,
  output logic full_o
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != LIM) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = inc_i && (cnt_q >= LIM_M1);
  assign full_o = (cnt_q == LIM);
endmodule

// File: rtl/cache_mem_arbiter.sv
// RAM port arbiter: dcache priority with block-long grants.
// ARB_FAIRNESS_EN adds a DLIMIT-word starvation guard for the icache.
module cache_mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter int unsigned DLIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);
  if (DLIMIT == 0 || (DLIMIT % 2) != 0) begin : g_bad_dlimit
    $error("DLIMIT must be even and nonzero");
  end

  arb_state_t state_q;
  arb_state_t state_d;

  logic dreq;
  logic acc;
  logic icomp;
  logic dcomp;
  logic f_rel;
  logic f_pri;

  assign dreq  = dREN | dWEN;
  assign acc   = (ramstate == ACCESS);
  assign icomp = (state_q == ARB_IGRANT) && iREN && acc;
  assign dcomp = (state_q == ARB_DGRANT) && dreq && acc;

`ifdef ARB_FAIRNESS_EN
  logic f_hit;
  logic f_full;
  logic f_clr;

  assign f_clr = icomp || ((state_d == ARB_IDLE) && !iREN);
  assign f_rel = f_hit && iREN;
  assign f_pri = f_full && iREN;

  arb_fair_cnt #(
    .LIMIT(DLIMIT)
  ) u_fair_cnt (
    .clk_i (CLK),
    .rst_ni(nRST),
    .inc_i (dcomp),
    .clr_i (f_clr),
    .hit_o (f_hit),
    .full_o(f_full)
  );
`else
  assign f_rel = 1'b0;
  assign f_pri = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (f_pri) begin
          state_d = ARB_IGRANT;
        end else if (dreq) begin
          state_d = ARB_DGRANT;
        end else if (iREN) begin
          state_d = ARB_IGRANT;
        end
      end
      ARB_IGRANT: begin
        if (!iREN || acc) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_DGRANT: begin
        // forced release lands only on a completion, i.e. a block edge
        if (!dreq || (dcomp && f_rel)) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      ARB_IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !icomp;
        iload   = ramload;
      end
      ARB_DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !dcomp;
        dload    = ramload;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level owner model plus
// directed block, error, fairness and async-reset scenarios.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int DLIMIT = 4;
  localparam int O_NONE = 0;
  localparam int O_I = 1;
  localparam int O_D = 2;

  logic CLK = 1'b0;
  logic nRST;
  logic iREN, dREN, dWEN;
  word_t iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic iwait, dwait, ramREN, ramWEN;
  word_t iload, dload, ramaddr, ramstore;

  int n_chk = 0;
  int n_pass = 0;
  int owner = O_NONE;
  int fcnt = 0;
  int icomp_cnt = 0;
  bit log_en = 0;
  word_t bus_log[$];
  word_t done_log[$];

  cache_mem_arbiter #(.DLIMIT(DLIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic bit fair_on();
`ifdef ARB_FAIRNESS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Who owns the RAM port, advanced by the arbitration rules per edge.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner = O_NONE;
      fcnt = 0;
    end else begin
      bit dq, ac;
      dq = dREN || dWEN;
      ac = (ramstate == ACCESS);
      case (owner)
        O_NONE: begin
          if (fair_on() && fcnt >= DLIMIT && iREN) owner = O_I;
          else if (dq) owner = O_D;
          else if (iREN) owner = O_I;
        end
        O_I: begin
          if (iREN && ac) fcnt = 0;
          if (ac || !iREN) owner = O_NONE;
        end
        default: begin
          if (!dq) owner = O_NONE;
          else if (ac) begin
            if (fcnt < DLIMIT) fcnt++;
            if (fair_on() && fcnt >= DLIMIT && iREN) owner = O_NONE;
          end
        end
      endcase
      if (owner == O_NONE && !iREN) fcnt = 0;
    end
  end

  always @(negedge CLK) begin
    bit ac, ic, dc;
    logic [65:0] ebus;
    ac = (ramstate == ACCESS);
    ic = (owner == O_I) && iREN && ac;
    dc = (owner == O_D) && (dREN || dWEN) && ac;
    case (owner)
      O_I: ebus = {iREN, 1'b0, iaddr, 32'h0};
      O_D: ebus = {dREN, dWEN, daddr, dstore};
      default: ebus = '0;
    endcase
    chk("bus", 128'({ramREN, ramWEN, ramaddr, ramstore}), 128'(ebus));
    chk("waits", 128'({iwait, dwait}), 128'({!ic, !dc}));
    if (ic) chk("iload", 128'(iload), 128'(ramload));
    if (owner != O_I) chk("iload0", 128'(iload), 128'(0));
    if (dc) chk("dload", 128'(dload), 128'(ramload));
    if (owner != O_D) chk("dload0", 128'(dload), 128'(0));
    if (!iwait) icomp_cnt++;
    if (log_en && (ramREN || ramWEN)) bus_log.push_back(ramaddr);
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic d_word(input bit rd, input word_t a, input word_t v,
                        input int nerr);
    bit g;
    g = 0;
    dREN = rd;
    dWEN = !rd;
    daddr = a;
    dstore = rd ? 32'h0 : v;
    ramstate = BUSY;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        g = 1;
        break;
      end
    end
    chk("dgrant", 128'(g), 128'(1));
    for (int k = 0; k < nerr; k++) begin
      nxt();
      ramstate = ERROR;
      @(negedge CLK);
      chk("err_dwait", 128'(dwait), 128'(1));
      chk("err_hold", 128'({ramREN, ramWEN, ramaddr}), 128'({rd, !rd, a}));
    end
    nxt();
    ramstate = ACCESS;
    ramload = rd ? v : 32'h0;
    @(negedge CLK);
    done_log.push_back(ramaddr);
    chk("dwait_done", 128'(dwait), 128'(0));
    if (rd) chk("dload_lit", 128'(dload), 128'(v));
    nxt();
    ramstate = BUSY;
    ramload = '0;
  endtask

  task automatic i_word(input word_t a, input word_t v, input int nbusy);
    bit g;
    g = 0;
    iREN = 1;
    iaddr = a;
    ramstate = BUSY;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (ramREN) begin
        g = 1;
        break;
      end
    end
    chk("igrant", 128'(g), 128'(1));
    for (int k = 1; k < nbusy; k++) begin
      nxt();
      @(negedge CLK);
      chk("ibusy_wait", 128'(iwait), 128'(1));
    end
    nxt();
    ramstate = ACCESS;
    ramload = v;
    @(negedge CLK);
    chk("iwait_done", 128'(iwait), 128'(0));
    chk("iload_lit", 128'(iload), 128'(v));
    nxt();
    ramstate = FREE;
    ramload = '0;
    iREN = 0;
    @(negedge CLK);
    chk("iwait_1cyc", 128'(iwait), 128'(1));
    chk("i_idle", 128'(ramREN), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int ic0;
    nRST = 0;
    iREN = 1;
    dREN = 1;
    dWEN = 0;
    iaddr = 32'h40;
    daddr = '0;
    dstore = '0;
    ramload = '0;
    ramstate = FREE;
    repeat (2) @(negedge CLK);
    chk("rst_iwait", 128'(iwait), 128'(1));
    chk("rst_dwait", 128'(dwait), 128'(1));
    chk("rst_ramREN", 128'(ramREN), 128'(0));
    nxt();
    nRST = 1;
    @(negedge CLK);
    chk("rst_idle", 128'(ramREN), 128'(0));
    @(negedge CLK);
    chk("rst_dgrant", 128'({ramREN, iwait}), 128'({1'b1, 1'b1}));
    nxt();
    dREN = 0;
    iREN = 0;
    nxt();

    i_word(32'h40, 32'h8C01_0004, 2);

    iREN = 1;
    iaddr = 32'h40;
    log_en = 1;
    done_log.delete();
    ic0 = icomp_cnt;
    d_word(0, 32'h100, 32'hA1, 0);
    d_word(0, 32'h104, 32'hA2, 0);
    d_word(1, 32'h200, 32'hB1, 0);
    d_word(1, 32'h204, 32'hB2, 0);
    dREN = 0;
    dWEN = 0;
    log_en = 0;
    chk("blk_n", 128'(done_log.size()), 128'(4));
    if (done_log.size() == 4) begin
      chk("blk_a0", 128'(done_log[0]), 128'(32'h100));
      chk("blk_a1", 128'(done_log[1]), 128'(32'h104));
      chk("blk_a2", 128'(done_log[2]), 128'(32'h200));
      chk("blk_a3", 128'(done_log[3]), 128'(32'h204));
    end
    seen = 0;
    foreach (bus_log[k]) if (bus_log[k] == 32'h40) seen = 1;
    chk("no_interleave", 128'(seen), 128'(0));
    chk("no_icomp_blk", 128'(icomp_cnt - ic0), 128'(0));
    i_word(32'h40, 32'h1122_3344, 1);

    d_word(1, 32'h300, 32'hDEAD_BEEF, 3);
    dREN = 0;
    nxt();

    iREN = 1;
    iaddr = 32'h40;
    ic0 = icomp_cnt;
`ifdef ARB_FAIRNESS_EN
    for (int k = 0; k < DLIMIT; k++) d_word(1, 32'h400 + 4 * k, 32'h50 + k, 0);
    @(negedge CLK);
    chk("fair_idle", 128'(ramREN), 128'(0));
    @(negedge CLK);
    chk("fair_igrant", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h40}));
    dREN = 0;
    i_word(32'h40, 32'h7777_0000, 1);
`else
    for (int k = 0; k < 6; k++) d_word(1, 32'h400 + 4 * k, 32'h50 + k, 0);
    chk("starve", 128'(icomp_cnt - ic0), 128'(0));
    dREN = 0;
    i_word(32'h40, 32'h7777_0000, 1);
`endif

    dREN = 1;
    daddr = 32'h500;
    ramstate = BUSY;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (ramREN) begin
        seen = 1;
        break;
      end
    end
    chk("ar_grant", 128'(seen), 128'(1));
    @(posedge CLK);
    #2;
    nRST = 0;
    #1;
    chk("ar_strobes", 128'({ramREN, ramWEN}), 128'(0));
    chk("ar_dwait", 128'(dwait), 128'(1));
    nxt();
    nRST = 1;
    dREN = 0;
    repeat (2) nxt();
    chk("ar_after", 128'(ramREN), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Single-port RAM arbiter between the instruction cache and the two-way data cache. Sits between both cache controllers and the memory interface, and grants the one RAM port to one requester at a time. A data-cache grant is held for a whole multi-word block transfer (writeback or load) so that a block is never interleaved with instruction fetches. Data-cache priority applies, with an optional starvation guard for the instruction cache.

## Interface
- DLIMIT, default 4: maximum consecutive completed data words before a waiting icache is served. Must be even. Used only with ARB_FAIRNESS_EN.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache stall; 0 only in the cycle its access completes.
- iload  out  32  read data to icache.
- dREN, dWEN  in  1 each  dcache read/write request (never both high).
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache stall; 0 only in the cycle its access completes.
- dload  out  32  read data to dcache.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from cpu_types_pkg.

## Operation
- FSM arb_state_t with three states: ARB_IDLE, ARB_IGRANT, ARB_DGRANT.
- ARB_IDLE:
  - dREN|dWEN -> ARB_DGRANT.
  - else iREN -> ARB_IGRANT.
  - Both requesting -> dcache wins (subject to the fairness rule below).
  - No RAM strobes are driven in this state.
- ARB_IGRANT:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - On ramstate==ACCESS: iwait=0, iload=ramload, next state ARB_IDLE. One word per grant.
  - iREN dropping before ACCESS -> ARB_IDLE.
- ARB_DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - On ACCESS: dwait=0, dload=ramload. The grant stays in place.
  - Grant released (-> ARB_IDLE) in the first cycle dREN|dWEN is low.
- ramstate BUSY, FREE or ERROR in a grant state:
  - Strobes stay asserted and the wait output stays 1.
  - ERROR does not complete an access.
- The non-granted requester always sees wait=1 and load=0.
- With no grant, ramaddr and ramstore are 0 and the strobes are 0.

## Timing
- Reset (nRST low, asynchronous) returns:
  - state ARB_IDLE, fairness count 0;
  - ramREN=ramWEN=0, ramaddr=ramstore=0;
  - iwait=dwait=1, iload=dload=0.
- Latency:
  - Request seen in cycle N -> grant state registered at edge N+1.
  - RAM strobes are combinational from the state in cycle N+1.
  - Completion occurs in the first cycle with ACCESS. Minimum 2 cycles from request to wait=0.
- All outputs are combinational from the registered state and current inputs. No combinational path from ramstate to the next-state of a non-granted requester.
- Simultaneous release and new request: dcache drops its request in the same cycle iREN is high -> ARB_IDLE for 1 cycle -> ARB_IGRANT. No same-cycle handoff.
- Reset mid-transfer: the grant is lost immediately and strobes drop in the same cycle. The caches re-request after reset.
- Requesters must hold address and data stable while wait=1.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A counter increments on each ACCESS completion in ARB_DGRANT.
  - When the count reaches DLIMIT and iREN is high, ARB_DGRANT -> ARB_IDLE after that completion, and ARB_IDLE then grants icache regardless of dcache requests.
  - The counter clears on any icache completion, or on entering ARB_IDLE with iREN low.
  - Since DLIMIT is even and blocks are 2 words, a forced release falls on a block boundary.
- ARB_FAIRNESS_EN undefined:
  - No counter is built and DLIMIT is ignored.
  - dcache keeps the grant for as long as it requests.

## Structure
- arb_state_t enum (ARB_IDLE, ARB_IGRANT, ARB_DGRANT) goes in cache_pkg alongside the cache state enums.
- ramstate_t and word_t come from cpu_types_pkg.
- One sub-module, arb_fair_cnt: the saturating count-to-DLIMIT counter with a clear input. It is instantiated only under ARB_FAIRNESS_EN.

## Test plan
- Reset: hold nRST low with iREN=dREN=1 -> iwait=dwait=1 and ramREN=0. Release reset -> dcache granted in the second cycle.
- icache fetch: iREN=1, iaddr=0x40, RAM gives BUSY×2 then ACCESS with ramload=0x8C010004 -> iwait=0 for exactly 1 cycle, iload=0x8C010004, then ARB_IDLE.
- Block writeback plus load: dWEN to 0x100/0x104, then dREN to 0x200/0x204, with iREN high throughout -> ramaddr sequence 0x100, 0x104, 0x200, 0x204 with no 0x40 interleaved. icache is served only after dcache drops its request.
- ERROR handling: ramstate=ERROR for 3 cycles during a dcache read -> dwait stays 1 and the strobes are held. ACCESS then completes the read normally.
- Fairness (ARB_FAIRNESS_EN, DLIMIT=4): dREN continuous with iREN high -> after 4 data completions, 1 idle cycle, then an icache grant. Without the macro, icache never completes while dREN stays high.
- Async reset mid-ARB_DGRANT: pull nRST low between clock edges -> ramREN/ramWEN drop immediately and dwait=1.
